codec_i2c_cmd_master: RTL and testbench

Command-level I2C master for the audio codec's control port. It sits directly downstream of the codec initialization FSM and consumes its command index and `send` request. It maps each index to a 16-bit codec register word and serializes the 3-byte write frame on the I2C bus. It reports acceptance with `ack` and completion with `ready`.

---
 rtl/codec_pkg.sv | 33 +++
 rtl/codec_i2c_tick.sv | 26 ++
 rtl/codec_i2c_cmd_master.sv | 100 ++++++++++
 tb/tb_codec_i2c_cmd_master.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// codec_pkg: shared codec command indices, I2C master states and the register-word LUT
package codec_pkg;
  localparam logic [3:0] DUMMY_DATA  = 4'd0;
  localparam logic [3:0] SET_LIN_L   = 4'd1;
  localparam logic [3:0] SET_LIN_R   = 4'd2;
  localparam logic [3:0] SET_HEAD_L  = 4'd3;
  localparam logic [3:0] SET_HEAD_R  = 4'd4;
  localparam logic [3:0] A_PATH_CTRL = 4'd5;
  localparam logic [3:0] D_PATH_CTRL = 4'd6;
  localparam logic [3:0] POWER_ON    = 4'd7;
  localparam logic [3:0] SET_FORMAT  = 4'd8;
  localparam logic [3:0] SAMPLE_CTRL = 4'd9;
  localparam logic [3:0] SET_ACTIVE  = 4'd10;
  localparam int INIT_CMDS_N = 11;
  localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;
  typedef enum logic [2:0] {IDLE, START, BYTE, ACKSLOT, STOP, DONE} i2c_state_t;
  function automatic logic [15:0] reg_word(input logic [3:0] idx);
    case (idx)
      DUMMY_DATA:  return 16'h1E00;
      SET_LIN_L:   return 16'h0017;
      SET_LIN_R:   return 16'h0217;
      SET_HEAD_L:  return 16'h0479;
      SET_HEAD_R:  return 16'h0679;
      A_PATH_CTRL: return 16'h0812;
      D_PATH_CTRL: return 16'h0A00;
      POWER_ON:    return 16'h0C00;
      SET_FORMAT:  return 16'h0E42;
      SAMPLE_CTRL: return 16'h1000;
      SET_ACTIVE:  return 16'h1201;
      default:     return 16'h0000;
    endcase
  endfunction
endpackage

// File: rtl/codec_i2c_tick.sv
// codec_i2c_tick: quarter-bit-period divider; tick ends each quarter, quarter counts 0..3
// ports: clk, rst (async, high), en (low holds counters at 0), tick, quarter
module codec_i2c_tick #(
  parameter int DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       tick,
  output logic [1:0] quarter
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      quarter <= '0;
    end else if (!en) begin
      cnt <= '0;
      quarter <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      quarter <= quarter + {1'b0, tick};
    end
endmodule

// File: rtl/codec_i2c_cmd_master.sv
// codec_i2c_cmd_master: maps a codec command index to a register word and writes it as a 3-byte I2C frame
// ports: clk, rst (async, high), cmd/send in; ack pulse, ready (idle), sticky nack_err/cmd_err;
//        i2c_sclk push-pull, i2c_sdat open-drain (0 or Z)
module codec_i2c_cmd_master
  import codec_pkg::*;
#(
  parameter int         CLK_HZ   = 50_000_000,
  parameter int         I2C_HZ   = 100_000,
  parameter logic [6:0] DEV_ADDR = CODEC_DEV_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cmd,
  input  logic       send,
  output logic       ack,
  output logic       ready,
  output logic       nack_err,
  output logic       cmd_err,
  output logic       i2c_sclk,
  inout  wire        i2c_sdat
);
  localparam int DIV = CLK_HZ / (4 * I2C_HZ);
  i2c_state_t state;
  logic [15:0] word;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt, quarter;
  logic armed, nack, sda_low, tick, en, end_bit, scl_n, sda_low_n;
  logic [7:0] cur_byte;
  // a rejected index parks in START without running the divider, so the bus stays idle
  assign en = state inside {START, BYTE, ACKSLOT, STOP} && !cmd_err;
  assign end_bit = tick && quarter == 2'd3;
  assign cur_byte = byte_cnt == 2'd0 ? {DEV_ADDR, 1'b0} : byte_cnt == 2'd1 ? word[15:8] : word[7:0];
  assign i2c_sdat = sda_low ? 1'b0 : 1'bz;
  codec_i2c_tick #(.DIV(DIV)) u_tick (.clk, .rst, .en, .tick, .quarter);
  always_comb begin
    scl_n = state == START ? quarter != 2'd3 : state == STOP ? quarter != 2'd0 :
            state inside {BYTE, ACKSLOT} ? quarter[0] ^ quarter[1] : 1'b1;
    sda_low_n = state == START ? quarter[1] : state == STOP ? !quarter[1] :
                state == BYTE ? !cur_byte[3'd7 - bit_cnt] : 1'b0;
  end
  // armed drops on acceptance and re-arms only once send has been seen low
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ack <= 1'b0;
      ready <= 1'b1;
      nack_err <= 1'b0;
      cmd_err <= 1'b0;
      i2c_sclk <= 1'b1;
      sda_low <= 1'b0;
      armed <= 1'b1;
      nack <= 1'b0;
      word <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
    end else begin
      ack <= 1'b0;
      i2c_sclk <= scl_n;
      sda_low <= sda_low_n;
      armed <= armed | !send;
      case (state)
        IDLE: if (send && armed) begin
          word <= reg_word(cmd);
          ack <= 1'b1;
          ready <= 1'b0;
          nack_err <= 1'b0;
          cmd_err <= cmd >= 4'(INIT_CMDS_N);
          armed <= 1'b0;
          state <= START;
        end
        START: state <= cmd_err ? DONE : end_bit ? BYTE : START;
        BYTE: if (end_bit) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= ACKSLOT;
        end
        ACKSLOT: begin
          if (tick && quarter == 2'd1) nack <= i2c_sdat;
          if (end_bit) begin
            if (nack) nack_err <= 1'b1;
            if (nack || byte_cnt == 2'd2) state <= STOP;
            else begin
              byte_cnt <= byte_cnt + 2'd1;
              state <= BYTE;
            end
          end
        end
        STOP: if (end_bit) begin
          ready <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          ready <= 1'b1;
          bit_cnt <= '0;
          byte_cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_codec_i2c_cmd_master.sv
// tb_codec_i2c_cmd_master: bus-level checks of the codec command master against a frame model
module tb_codec_i2c_cmd_master;
  localparam int CLK_HZ = 4_000_000;
  localparam int I2C_HZ = 100_000;
  localparam int DIV = CLK_HZ / (4 * I2C_HZ);
  logic clk = 0, rst = 1, send = 0, slave_low = 0;
  logic [3:0] cmd = 0;
  logic ack, ready, nack_err, cmd_err, i2c_sclk;
  wire i2c_sdat;
  pullup (i2c_sdat);
  assign i2c_sdat = slave_low ? 1'b0 : 1'bz;
  codec_i2c_cmd_master #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ), .DEV_ADDR(7'h1A)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .send(send), .ack(ack), .ready(ready),
    .nack_err(nack_err), .cmd_err(cmd_err), .i2c_sclk(i2c_sclk), .i2c_sdat(i2c_sdat));
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int nack_at;
    bit exp_nack;
    bit exp_cerr;
    int nb;
  } vec_t;
  vec_t vecs[8];
  logic [15:0] words [0:10];
  int checks = 0, failures = 0;

  logic [7:0] rx_q[$];
  logic [7:0] sh = 0;
  int starts = 0, stops = 0, scl_rises = 0, bitn = 0, nb_frame = 0, nack_policy = 3, stray = 0;
  logic prev_scl = 1, prev_sda = 1, prev_ready = 1;

  // passive I2C slave: decodes START/STOP/bits and ACKs every byte except the one at nack_policy
  always @(negedge clk) begin
    logic s, d;
    if (rst) begin
      prev_scl = 1;
      prev_sda = 1;
      bitn = 0;
      nb_frame = 0;
      slave_low = 0;
    end else begin
      s = i2c_sclk;
      d = i2c_sdat;
      if (prev_scl && s && prev_sda && !d) begin
        starts++;
        bitn = 0;
        nb_frame = 0;
      end else if (prev_scl && s && !prev_sda && d) stops++;
      else if (!prev_scl && s) begin
        scl_rises++;
        if (bitn < 8) begin
          sh = {sh[6:0], d};
          bitn++;
        end else begin
          rx_q.push_back(sh);
          nb_frame++;
          bitn = 0;
        end
      end else if (prev_scl && !s) slave_low = (bitn == 8) && (nb_frame != nack_policy);
      prev_scl = s;
      prev_sda = d;
    end
  end

  always @(negedge clk) begin
    if (ack && !prev_ready) stray++;
    prev_ready = ready;
  end

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int model_nb(input int idx, input int nack_at);
    return idx > 10 ? 0 : nack_at < 3 ? nack_at + 1 : 3;
  endfunction

  function automatic int model_lat(input int idx, input int nb);
    return idx > 10 ? 2 : 4 * DIV * (2 + 9 * nb);
  endfunction

  function automatic logic [7:0] exp_byte(input int idx, input int i);
    logic [15:0] w;
    w = words[idx];
    return i == 0 ? 8'h34 : i == 1 ? w[15:8] : w[7:0];
  endfunction

  task automatic run_cmd(input int idx, input int nack_at, input bit b2b,
                         input bit exp_nack, input bit exp_cerr, input int nb);
    int rx0, st0, sp0, sr0, acks, n, lat;
    bit got;
    n = 0;
    while (!ready && n < 200 * DIV) begin
      @(negedge clk);
      n++;
    end
    check("idle_before_send", ready, 1);
    if (!b2b) @(negedge clk);
    rx0 = rx_q.size();
    st0 = starts;
    sp0 = stops;
    sr0 = scl_rises;
    nack_policy = nack_at;
    cmd = 4'(idx);
    send = 1;
    n = 0;
    got = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      got = ack;
    end
    send = 0;
    check("ack_seen", got, 1);
    if (b2b) check("ack_lat_b2b", int'(n >= 1 && n <= 2), 1);
    else check("ack_lat", n, 1);
    check("ready_low_at_ack", ready, 0);
    acks = 1;
    lat = 0;
    while (!ready && lat < 200 * DIV) begin
      @(negedge clk);
      lat++;
      if (ack) acks++;
    end
    check("ready_lat", lat, model_lat(idx, nb));
    check("ack_cnt", acks, 1);
    check("nack_err", nack_err, exp_nack);
    check("cmd_err", cmd_err, exp_cerr);
    check("rx_bytes", rx_q.size() - rx0, nb);
    for (int i = 0; i < nb; i++)
      if (rx0 + i < rx_q.size()) check("rx_byte", rx_q[rx0 + i], exp_byte(idx, i));
    check("starts", starts - st0, nb > 0 ? 1 : 0);
    check("stops", stops - sp0, nb > 0 ? 1 : 0);
    check("scl_rises", scl_rises - sr0, nb > 0 ? 9 * nb + 1 : 0);
    nack_policy = 3;
  endtask

  initial begin
    int idx, na, n, acks, st0, sp0, rx0;
    bit found;
    words = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
              16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201};
    vecs[0] = '{idx: 8, nack_at: 3, exp_nack: 0, exp_cerr: 0, nb: 3};
    vecs[1] = '{idx: 3, nack_at: 1, exp_nack: 1, exp_cerr: 0, nb: 2};
    vecs[2] = '{idx: 5, nack_at: 3, exp_nack: 0, exp_cerr: 0, nb: 3};
    vecs[3] = '{idx: 12, nack_at: 3, exp_nack: 0, exp_cerr: 1, nb: 0};
    vecs[4] = '{idx: 0, nack_at: 0, exp_nack: 1, exp_cerr: 0, nb: 1};
    vecs[5] = '{idx: 15, nack_at: 3, exp_nack: 0, exp_cerr: 1, nb: 0};
    vecs[6] = '{idx: 10, nack_at: 2, exp_nack: 1, exp_cerr: 0, nb: 3};
    vecs[7] = '{idx: 1, nack_at: 3, exp_nack: 0, exp_cerr: 0, nb: 3};
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_ack", ack, 0);
    check("rst_nack_err", nack_err, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_scl", i2c_sclk, 1);
    check("rst_sda", i2c_sdat, 1);
    rst = 0;
    repeat (2) @(negedge clk);
    for (int v = 0; v < 8; v++)
      run_cmd(vecs[v].idx, vecs[v].nack_at, 0, vecs[v].exp_nack, vecs[v].exp_cerr, vecs[v].nb);
    for (int i = 0; i < 11; i++) run_cmd(i, 3, 1, 0, 0, 3);
    for (int r = 0; r < 12; r++) begin
      idx = int'($urandom_range(0, 15));
      na = int'($urandom_range(0, 5));
      run_cmd(idx, na, r[0], idx < 11 && na < 3, idx > 10, model_nb(idx, na));
    end
    @(negedge clk);
    cmd = 2;
    send = 1;
    n = 0;
    while (!ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    send = 0;
    check("rst_test_ack", ack, 1);
    n = 0;
    found = 0;
    while (!found && n < 200 * DIV) begin
      @(negedge clk);
      n++;
      found = nb_frame == 1 && bitn == 5 && !i2c_sclk;
    end
    check("reach_bit5", found, 1);
    #2 rst = 1;
    #1;
    check("midrst_scl", i2c_sclk, 1);
    check("midrst_sda", i2c_sdat, 1);
    check("midrst_ready", ready, 1);
    check("midrst_ack", ack, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    run_cmd(2, 3, 0, 0, 0, 3);
    @(negedge clk);
    st0 = starts;
    sp0 = stops;
    rx0 = rx_q.size();
    cmd = 4;
    send = 1;
    acks = 0;
    for (int i = 0; i < 116 * DIV + 40; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("hold_acks", acks, 1);
    check("hold_starts", starts - st0, 1);
    check("hold_stops", stops - sp0, 1);
    check("hold_rx", rx_q.size() - rx0, 3);
    check("hold_ready", ready, 1);
    send = 0;
    run_cmd(6, 3, 0, 0, 0, 3);
    check("stray_ack", stray, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
